// File: rtl/drum_audio_bridge_pkg.sv
// Shared drum-grid / audio constants: 1.17 sample width, PCM width and PCM limits.
package drum_audio_bridge_pkg;

    localparam int unsigned SAMPLE_W = 18;
    localparam int unsigned PCM_W    = 16;
    localparam int          PCM_MAX  = 32767;
    localparam int          PCM_MIN  = -32768;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSendL = 2'd1,
        StSendR = 2'd2
    } out_state_e;

endpackage

// File: rtl/sample_fifo_mem.sv
// Simple dual-port sample store with registered read; no reset so it maps onto block RAM.
module sample_fifo_mem #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WIDTH  = 18,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/drum_audio_bridge.sv
// Buffers drum-grid center samples in a FIFO and emits each as a left/right PCM word pair
// over a valid/ready handshake to the audio codec.
module drum_audio_bridge
    import drum_audio_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned GAIN_SHIFT = 0
) (
    input  logic                       clk_50,
    input  logic                       reset_n,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    output logic        [PCM_W-1:0]    audio_data,
    output logic                       audio_chan,
    output logic                       audio_valid,
    input  logic                       audio_ready,
    output logic        [15:0]         drop_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned XW = SAMPLE_W + GAIN_SHIFT;

    out_state_e                 r_state;
    logic        [AW-1:0]       r_wr_ptr;
    logic        [AW-1:0]       r_rd_ptr;
    logic        [CW-1:0]       r_count;
    logic        [15:0]         r_drop;
    logic        [PCM_W-1:0]    r_hold;
    logic                       r_valid;
    logic                       r_chan;
    logic                       r_byp_vld;
    logic signed [SAMPLE_W-1:0] r_byp_data;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_drop;
    logic        [AW-1:0]       w_rd_ptr_next;
    logic signed [SAMPLE_W-1:0] w_mem_rd_data;
    logic signed [SAMPLE_W-1:0] w_head;
    logic signed [XW-1:0]       w_x;
    logic signed [XW-1:0]       w_y;
    logic        [PCM_W-1:0]    w_pcm;

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign sample_ready  = (r_count < CW'(FIFO_DEPTH));
    assign w_push        = sample_valid && sample_ready;
    assign w_drop        = sample_valid && !sample_ready;
    assign w_pop         = (r_state == StIdle) && (r_count != '0);
    assign w_rd_ptr_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

    // The RAM always pre-reads the entry that will be head next cycle.
    sample_fifo_mem #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W),
        .ADDR_W(AW)
    ) u_mem (
        .i_clk    (clk_50),
        .i_wr_en  (w_push),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(sample_in),
        .i_rd_addr(w_rd_ptr_next),
        .o_rd_data(w_mem_rd_data)
    );

    // A write landing on the pre-read address returns stale RAM data, so forward it instead.
    assign w_head = r_byp_vld ? r_byp_data : w_mem_rd_data;

    assign w_x = XW'(w_head) <<< GAIN_SHIFT;
    assign w_y = w_x >>> 2;

    always_comb begin
        w_pcm = w_y[PCM_W-1:0];
        if (int'(w_y) > PCM_MAX) begin
            w_pcm = PCM_W'(PCM_MAX);
        end else if (int'(w_y) < PCM_MIN) begin
            w_pcm = PCM_W'(PCM_MIN);
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop     <= '0;
            r_byp_vld  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                r_byp_data <= sample_in;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_byp_vld <= w_push && (r_wr_ptr == w_rd_ptr_next);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_chan  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_hold  <= w_pcm;
                        r_valid <= 1'b1;
                        r_chan  <= 1'b0;
                        r_state <= StSendL;
                    end
                end
                StSendL: begin
                    if (audio_ready) begin
                        r_chan  <= 1'b1;
                        r_state <= StSendR;
                    end
                end
                StSendR: begin
                    if (audio_ready) begin
                        r_valid <= 1'b0;
                        r_chan  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_chan  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign audio_data  = r_hold;
    assign audio_chan  = r_chan;
    assign audio_valid = r_valid;
    assign drop_count  = r_drop;

endmodule
